// File: rtl/usb_defs_pkg.sv
// usb_defs_pkg: PID codes, response status, engine states and
// the bundles shared by the host-side transaction engine.
package usb_defs_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_TIMEOUT  = 2'd1,
        ST_OVERFLOW = 2'd2,
        ST_BADLEN   = 2'd3
    } rsp_status_t;

    typedef enum logic [2:0] {
        S_IDLE, S_TOKEN, S_DATA, S_GAPW, S_WAIT_RSP, S_CAPTURE, S_DONE
    } state_t;

    // Command fields latched at accept time
    typedef struct packed {
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  ep;
        logic [15:0] len;
        logic        rsp_en;
        logic        crc_inj;
    } cmd_t;

    // Registered host bus drive toward the device core
    typedef struct packed {
        logic        pkt_valid;
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  ep;
        logic [7:0]  data;
        logic        data_valid;
        logic        crc_err;
    } host_out_t;

endpackage

// File: rtl/usb_txn_buf.sv
// usb_txn_buf: DEPTH x 8 simple dual-port RAM,
// one write port and a registered (1-cycle) read port.
module usb_txn_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    // Storage array, contents are not reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Synchronous read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/usb_host_txn_engine.sv
// usb_host_txn_engine: issues one token (+payload) on the host bus,
// then captures the device response with timeout and overflow tracking.
module usb_host_txn_engine
    import usb_defs_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_pid,
    input  logic [6:0]               cmd_addr,
    input  logic [3:0]               cmd_ep,
    input  logic [15:0]              cmd_len,
    input  logic                     cmd_rsp_en,
    input  logic                     cmd_crc_inj,
    input  logic                     pl_wr_en,
    input  logic [$clog2(DEPTH)-1:0] pl_wr_addr,
    input  logic [7:0]               pl_wr_data,
    output logic                     host_pkt_valid,
    output logic [3:0]               host_pid,
    output logic [6:0]               host_addr,
    output logic [3:0]               host_ep,
    output logic [15:0]              host_data_len,
    output logic [7:0]               host_data,
    output logic                     host_data_valid,
    output logic                     host_crc_err,
    input  logic                     host_tx_valid,
    input  logic [3:0]               host_tx_pid,
    input  logic [7:0]               host_tx_data,
    input  logic [15:0]              host_tx_len,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_status,
    output logic [3:0]               rsp_pid,
    output logic [15:0]              rsp_len,
    input  logic [$clog2(DEPTH)-1:0] rb_addr,
    output logic [7:0]               rb_data
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              TW      = $clog2(TIMEOUT + 1);
    localparam logic [15:0]     DEPTH16 = 16'(DEPTH);
    localparam logic [TW-1:0]   TMAX    = TW'(TIMEOUT - 1);
    localparam logic [3:0]      GMAX    = 4'(GAP - 1);

    state_t        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    host_out_t     ho_q, ho_d;
    logic [15:0]   idx_q, idx_d, cnt_q, cnt_d, rlen_q, rlen_d;
    logic [3:0]    gap_q, gap_d, rpid_q, rpid_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
    rsp_status_t   rsp_status_q, rsp_status_d, fin_st;
    logic [3:0]    rsp_pid_q, rsp_pid_d, fin_pid;
    logic [15:0]   rsp_len_q, rsp_len_d, fin_len;
    logic          tail, fin, rb_we;
    logic [7:0]    pl_rdata;

    function automatic logic [15:0] sat(input logic [15:0] n);
        return (n > DEPTH16) ? DEPTH16 : n;
    endfunction

    // Payload is read one step ahead so host_data registers in sync with its strobe
    usb_txn_buf #(.DEPTH(DEPTH)) u_pl_buf (
        .clk(clk), .rst_n(rst_n),
        .we(pl_wr_en && cmd_ready_q), .waddr(pl_wr_addr), .wdata(pl_wr_data),
        .raddr(idx_d[AW-1:0]), .rdata(pl_rdata)
    );

    usb_txn_buf #(.DEPTH(DEPTH)) u_rsp_buf (
        .clk(clk), .rst_n(rst_n),
        .we(rb_we), .waddr(cnt_q[AW-1:0]), .wdata(host_tx_data),
        .raddr(rb_addr), .rdata(rb_data)
    );

    // State, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            ho_q         <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            rlen_q       <= '0;
            gap_q        <= '0;
            rpid_q       <= '0;
            timer_q      <= '0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_pid_q    <= '0;
            rsp_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            ho_q         <= ho_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            rlen_q       <= rlen_d;
            gap_q        <= gap_d;
            rpid_q       <= rpid_d;
            timer_q      <= timer_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_pid_q    <= rsp_pid_d;
            rsp_len_q    <= rsp_len_d;
        end
    end

    // Next-state, counters and next values of the output registers
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        rlen_d       = rlen_q;
        gap_d        = gap_q;
        rpid_d       = rpid_q;
        timer_d      = timer_q;
        rsp_status_d = rsp_status_q;
        rsp_pid_d    = rsp_pid_q;
        rsp_len_d    = rsp_len_q;
        tail         = 1'b0;
        fin          = 1'b0;
        fin_st       = ST_OK;
        fin_pid      = '0;
        fin_len      = '0;
        rb_we        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len > DEPTH16) begin
                        fin    = 1'b1;
                        fin_st = ST_BADLEN;
                    end else begin
                        cmd_d   = '{cmd_pid, cmd_addr, cmd_ep, cmd_len,
                                    cmd_rsp_en, cmd_crc_inj};
                        idx_d   = '0;
                        state_d = S_TOKEN;
                    end
                end
            end
            S_TOKEN: begin
                if (cmd_q.len != 16'd0 && cmd_q.pid != PID_IN) state_d = S_DATA;
                else tail = 1'b1;
            end
            S_DATA: begin
                if (GAP != 0) begin
                    state_d = S_GAPW;
                    gap_d   = '0;
                end else if (idx_q == cmd_q.len) tail = 1'b1;
                else state_d = S_DATA;
            end
            S_GAPW: begin
                if (gap_q == GMAX) begin
                    if (idx_q == cmd_q.len) tail = 1'b1;
                    else state_d = S_DATA;
                end else gap_d = gap_q + 4'd1;
            end
            S_WAIT_RSP: begin
                if (host_tx_valid) begin
                    rpid_d  = host_tx_pid;
                    rlen_d  = host_tx_len;
                    timer_d = '0;
                    if (host_tx_len == 16'd0) begin
                        fin     = 1'b1;
                        fin_pid = host_tx_pid;
                    end else begin
                        rb_we = 1'b1;
                        cnt_d = 16'd1;
                        if (host_tx_len == 16'd1) begin
                            fin     = 1'b1;
                            fin_pid = host_tx_pid;
                            fin_len = 16'd1;
                        end else state_d = S_CAPTURE;
                    end
                end else if (timer_q == TMAX) begin
                    fin    = 1'b1;
                    fin_st = ST_TIMEOUT;
                end else timer_d = timer_q + TW'(1);
            end
            S_CAPTURE: begin
                if (host_tx_valid) begin
                    timer_d = '0;
                    rb_we   = (cnt_q < DEPTH16);
                    cnt_d   = cnt_q + 16'd1;
                    if (cnt_d == rlen_q) begin
                        fin     = 1'b1;
                        fin_pid = rpid_q;
                        fin_len = sat(cnt_d);
                        fin_st  = (rlen_q > DEPTH16) ? ST_OVERFLOW : ST_OK;
                    end
                end else if (timer_q == TMAX) begin
                    fin     = 1'b1;
                    fin_st  = ST_TIMEOUT;
                    fin_pid = rpid_q;
                    fin_len = sat(cnt_q);
                end else timer_d = timer_q + TW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (tail) begin
            if (cmd_q.rsp_en) begin
                state_d = S_WAIT_RSP;
                timer_d = '0;
                cnt_d   = '0;
            end else fin = 1'b1;
        end
        if (fin) begin
            state_d      = S_DONE;
            rsp_status_d = fin_st;
            rsp_pid_d    = fin_pid;
            rsp_len_d    = fin_len;
        end
        ho_d           = '0;
        ho_d.pkt_valid = (state_d == S_TOKEN) || (state_d == S_DATA);
        if (state_d == S_TOKEN) begin
            ho_d.pid  = cmd_d.pid;
            ho_d.addr = cmd_d.addr;
            ho_d.ep   = cmd_d.ep;
        end
        if (state_d == S_DATA) begin
            ho_d.data_valid = 1'b1;
            ho_d.data       = pl_rdata;
            ho_d.crc_err    = cmd_q.crc_inj && (idx_q == cmd_q.len - 16'd1);
            idx_d           = idx_q + 16'd1;
        end
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
    end

    assign cmd_ready       = cmd_ready_q;
    assign host_pkt_valid  = ho_q.pkt_valid;
    assign host_pid        = ho_q.pid;
    assign host_addr       = ho_q.addr;
    assign host_ep         = ho_q.ep;
    assign host_data_len   = cmd_q.len;
    assign host_data       = ho_q.data;
    assign host_data_valid = ho_q.data_valid;
    assign host_crc_err    = ho_q.crc_err;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_status      = rsp_status_q;
    assign rsp_pid         = rsp_pid_q;
    assign rsp_len         = rsp_len_q;

endmodule
